// File: rtl/memory_ctrl.sv
// memory_ctrl: single-port word array shared by a CPU port (byte-masked,
// with error reporting) and a debug port (full-word only).
//
// Handshake: a requester raises *_req_i and holds it, with stable command
// fields, until it sees its one-cycle completion pulse (cpu_ready_o or
// dbg_ack_o). The access is performed at the granting edge; the pulse is
// high for exactly the following cycle, during which all requests are
// ignored. A request dropped before it is granted has no effect.
module memory_ctrl #(
    parameter int                    MEM_BITS = 16,
    parameter logic [31-MEM_BITS:0]  BASE     = 16'h1000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    // CPU port
    input  logic        cpu_req_i,
    input  logic        cpu_write_i,
    input  logic [31:0] cpu_address_i,
    input  logic [31:0] cpu_wrdata_i,
    input  logic [3:0]  cpu_wrbits_i,
    output logic        cpu_ready_o,
    output logic [31:0] cpu_rddata_o,
    output logic        cpu_error_o,
    // debug port
    input  logic        dbg_req_i,
    input  logic        dbg_write_i,
    input  logic [31:0] dbg_address_i,
    input  logic [31:0] dbg_in_i,
    output logic        dbg_ack_o,
    output logic [31:0] dbg_out_o,
    // FSM state, exposed for observation
    output logic [1:0]  state_o
);

    localparam int IDX_W = MEM_BITS - 2;
    localparam int DEPTH = 1 << IDX_W;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DONE_CPU = 2'd1,
        DONE_DBG = 2'd2
    } state_e;

    state_e      state_q;
    logic        last_dbg_q;      // 1 = debug was granted last
    logic        cpu_ready_q;
    logic        cpu_error_q;
    logic        dbg_ack_q;
    logic [31:0] cpu_rddata_q;
    logic [31:0] dbg_out_q;

    logic [31:0] mem_q [DEPTH];

    logic             grant_cpu;
    logic             grant_dbg;
    logic [31:0]      acc_addr;
    logic             acc_write;
    logic [31:0]      acc_wdata;
    logic [3:0]       acc_be;
    logic             acc_legal;
    logic [IDX_W-1:0] acc_idx;
    logic [31:0]      rd_result;
    logic             mem_we;

    // Arbitration: a lone request wins; on a tie the port not granted last wins.
    always_comb begin
        grant_cpu = 1'b0;
        grant_dbg = 1'b0;
        if (rst_ni && (state_q == IDLE)) begin
            if (cpu_req_i && (!dbg_req_i || last_dbg_q)) begin
                grant_cpu = 1'b1;
            end else if (dbg_req_i) begin
                grant_dbg = 1'b1;
            end
        end
    end

    // Select the granted port's command and decode the address window.
    always_comb begin
        acc_addr  = grant_dbg ? dbg_address_i : cpu_address_i;
        acc_write = grant_dbg ? dbg_write_i   : cpu_write_i;
        acc_wdata = grant_dbg ? dbg_in_i      : cpu_wrdata_i;
        acc_be    = grant_dbg ? 4'hF          : cpu_wrbits_i;
        acc_legal = (acc_addr[31:MEM_BITS] == BASE) && (acc_addr[1:0] == 2'b00);
        acc_idx   = acc_addr[MEM_BITS-1:2];
        rd_result = acc_legal ? mem_q[acc_idx] : 32'h0;
        mem_we    = (grant_cpu || grant_dbg) && acc_legal && acc_write;
    end

    // Array write at the granting edge; contents survive reset.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_be[i]) begin
                    mem_q[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
                end
            end
        end
    end

    // Control FSM with registered completion pulses and read-data holding registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            last_dbg_q   <= 1'b1;
            cpu_ready_q  <= 1'b0;
            cpu_error_q  <= 1'b0;
            dbg_ack_q    <= 1'b0;
            cpu_rddata_q <= 32'h0;
            dbg_out_q    <= 32'h0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_cpu) begin
                        state_q     <= DONE_CPU;
                        last_dbg_q  <= 1'b0;
                        cpu_ready_q <= 1'b1;
                        cpu_error_q <= !acc_legal;
                        if (!acc_write) begin
                            cpu_rddata_q <= rd_result;
                        end
                    end else if (grant_dbg) begin
                        state_q    <= DONE_DBG;
                        last_dbg_q <= 1'b1;
                        dbg_ack_q  <= 1'b1;
                        if (!acc_write) begin
                            dbg_out_q <= rd_result;
                        end
                    end
                end
                DONE_CPU, DONE_DBG: begin
                    state_q     <= IDLE;
                    cpu_ready_q <= 1'b0;
                    cpu_error_q <= 1'b0;
                    dbg_ack_q   <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign cpu_ready_o  = cpu_ready_q;
    assign cpu_error_o  = cpu_error_q;
    assign cpu_rddata_o = cpu_rddata_q;
    assign dbg_ack_o    = dbg_ack_q;
    assign dbg_out_o    = dbg_out_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_memory_ctrl.sv
// Testbench for memory_ctrl: directed scenarios plus a random mix, with a
// reference memory model feeding per-port expected queues.
module tb_memory_ctrl;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        cpu_req = 1'b0, cpu_write = 1'b0;
    logic [31:0] cpu_address = '0, cpu_wrdata = '0;
    logic [3:0]  cpu_wrbits = '0;
    logic        cpu_ready, cpu_error;
    logic [31:0] cpu_rddata;
    logic        dbg_req = 1'b0, dbg_write = 1'b0;
    logic [31:0] dbg_address = '0, dbg_in = '0;
    logic        dbg_ack;
    logic [31:0] dbg_out;
    logic [1:0]  state;

    memory_ctrl dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .cpu_req_i    (cpu_req),
        .cpu_write_i  (cpu_write),
        .cpu_address_i(cpu_address),
        .cpu_wrdata_i (cpu_wrdata),
        .cpu_wrbits_i (cpu_wrbits),
        .cpu_ready_o  (cpu_ready),
        .cpu_rddata_o (cpu_rddata),
        .cpu_error_o  (cpu_error),
        .dbg_req_i    (dbg_req),
        .dbg_write_i  (dbg_write),
        .dbg_address_i(dbg_address),
        .dbg_in_i     (dbg_in),
        .dbg_ack_o    (dbg_ack),
        .dbg_out_o    (dbg_out),
        .state_o      (state)
    );

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_err = 0;
    logic [32:0] exp_cpu_q[$];   // {error, rddata}
    logic [31:0] exp_dbg_q[$];
    logic [31:0] model_mem [int];
    logic [31:0] cpu_last = 32'h0;
    logic [31:0] dbg_last = 32'h0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic is_legal(input logic [31:0] a);
        return (a[31:16] == 16'h1000) && (a[1:0] == 2'b00);
    endfunction

    function automatic int word_of(input logic [31:0] a);
        return int'(a[15:2]);
    endfunction

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        if (model_mem.exists(word_of(a))) return model_mem[word_of(a)];
        return 32'h0;
    endfunction

    task automatic model_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        logic [31:0] m;
        m = model_rd(a);
        for (int i = 0; i < 4; i++) begin
            if (be[i]) m[8*i +: 8] = d[8*i +: 8];
        end
        model_mem[word_of(a)] = m;
    endtask

    // Predict one CPU access and push its expected completion.
    task automatic predict_cpu(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        if (is_legal(a)) begin
            if (w) model_wr(a, d, be);
            else   cpu_last = model_rd(a);
        end else if (!w) begin
            cpu_last = 32'h0;
        end
        exp_cpu_q.push_back({!is_legal(a), cpu_last});
    endtask

    task automatic predict_dbg(input logic w, input logic [31:0] a, input logic [31:0] d);
        if (is_legal(a)) begin
            if (w) model_wr(a, d, 4'hF);
            else   dbg_last = model_rd(a);
        end else if (!w) begin
            dbg_last = 32'h0;
        end
        exp_dbg_q.push_back(dbg_last);
    endtask

    // Monitor: pop and compare on every completion pulse.
    always @(negedge clk) begin
        logic [32:0] ce;
        logic [31:0] de;
        if (rst_n) begin
            if (cpu_ready) begin
                if (exp_cpu_q.size() == 0) begin
                    check("cpu_unexpected_ready", 1, 0);
                end else begin
                    ce = exp_cpu_q.pop_front();
                    check("cpu_rddata", cpu_rddata, ce[31:0]);
                    check("cpu_error", cpu_error, ce[32]);
                end
            end else begin
                check("cpu_error_without_ready", cpu_error, 0);
            end
            if (dbg_ack) begin
                if (exp_dbg_q.size() == 0) begin
                    check("dbg_unexpected_ack", 1, 0);
                end else begin
                    de = exp_dbg_q.pop_front();
                    check("dbg_out", dbg_out, de);
                end
            end
        end
    end

    // ---------------- driver tasks (called at a negedge, state IDLE) ----------------
    task automatic cpu_access(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        int n;
        predict_cpu(w, a, d, be);
        cpu_req = 1'b1; cpu_write = w; cpu_address = a; cpu_wrdata = d; cpu_wrbits = be;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cpu_ready && n < 10);
        check("cpu_latency", n, 1);
        cpu_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic dbg_access(input logic w, input logic [31:0] a, input logic [31:0] d);
        int n;
        predict_dbg(w, a, d);
        dbg_req = 1'b1; dbg_write = w; dbg_address = a; dbg_in = d;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!dbg_ack && n < 10);
        check("dbg_latency", n, 1);
        dbg_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_state"}, state, 0);
        check({tag, "_cpu_ready"}, cpu_ready, 0);
        check({tag, "_cpu_error"}, cpu_error, 0);
        check({tag, "_cpu_rddata"}, cpu_rddata, 0);
        check({tag, "_dbg_ack"}, dbg_ack, 0);
        check({tag, "_dbg_out"}, dbg_out, 0);
    endtask

    logic [31:0] addr_tbl [6] = '{32'h1000_0010, 32'h1000_0014, 32'h1000_FFFC,
                                  32'h1000_0000, 32'h2000_0010, 32'h1000_0012};
    logic [1:0] tie_pat [7] = '{2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01};

    // ---------------- main sequence ----------------
    initial begin
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // full write then read
        cpu_access(1'b1, 32'h1000_0010, 32'hAABBCCDD, 4'b1111);
        cpu_access(1'b0, 32'h1000_0010, 32'h0, 4'h0);
        check("read_full_word", cpu_rddata, 32'hAABBCCDD);

        // masked write
        cpu_access(1'b1, 32'h1000_0010, 32'h11223344, 4'b0101);
        cpu_access(1'b0, 32'h1000_0010, 32'h0, 4'h0);
        check("read_masked_word", cpu_rddata, 32'hAA22CC44);

        // illegal accesses: wrong base, misaligned, illegal write
        cpu_access(1'b0, 32'h2000_0000, 32'h0, 4'h0);
        cpu_access(1'b0, 32'h1000_0002, 32'h0, 4'h0);
        cpu_access(1'b1, 32'h2000_0010, 32'hFFFF_FFFF, 4'hF);
        cpu_access(1'b1, 32'h1000_0011, 32'hFFFF_FFFF, 4'hF);
        // zero mask write
        cpu_access(1'b1, 32'h1000_0010, 32'h0BAD_0BAD, 4'b0000);
        cpu_access(1'b0, 32'h1000_0010, 32'h0, 4'h0);
        check("read_after_illegal_and_zero_mask", cpu_rddata, 32'hAA22CC44);

        // debug write at the top of the window, neighbour unaffected
        cpu_access(1'b1, 32'h1000_0000, 32'h0123_4567, 4'hF);
        dbg_access(1'b1, 32'h1000_FFFC, 32'h5A5A5A5A);
        cpu_access(1'b0, 32'h1000_FFFC, 32'h0, 4'h0);
        check("read_top_word", cpu_rddata, 32'h5A5A5A5A);
        cpu_access(1'b0, 32'h1000_0000, 32'h0, 4'h0);
        check("read_bottom_word", cpu_rddata, 32'h0123_4567);
        dbg_access(1'b0, 32'h1000_FFFC, 32'h0);
        dbg_access(1'b0, 32'h1001_0000, 32'h0);     // next window: illegal, no wrap
        dbg_access(1'b1, 32'h1001_0000, 32'hDEAD_0000);
        cpu_access(1'b0, 32'h1000_0000, 32'h0, 4'h0);

        // request raised during DONE_DBG and dropped before any grant
        cpu_access(1'b1, 32'h1000_0030, 32'h0102_0304, 4'hF);
        predict_dbg(1'b0, 32'h1000_0010, 32'h0);
        dbg_req = 1'b1; dbg_write = 1'b0; dbg_address = 32'h1000_0010;
        @(negedge clk);
        check("drop_dbg_ack", dbg_ack, 1);
        dbg_req = 1'b0;
        cpu_req = 1'b1; cpu_write = 1'b1; cpu_address = 32'h1000_0030;
        cpu_wrdata = 32'hDEAD_BEEF; cpu_wrbits = 4'hF;
        @(negedge clk);
        cpu_req = 1'b0;
        repeat (2) @(negedge clk);
        cpu_access(1'b0, 32'h1000_0030, 32'h0, 4'h0);
        check("dropped_request_no_write", cpu_rddata, 32'h0102_0304);

        // reset during DONE_CPU after a write
        predict_cpu(1'b1, 32'h1000_0020, 32'hCAFE_F00D, 4'hF);
        cpu_req = 1'b1; cpu_write = 1'b1; cpu_address = 32'h1000_0020;
        cpu_wrdata = 32'hCAFE_F00D; cpu_wrbits = 4'hF;
        @(negedge clk);
        check("rst_mid_ready_before", cpu_ready, 1);
        #2 rst_n = 1'b0;
        #1 check("rst_mid_ready_dropped", cpu_ready, 0);
        check("rst_mid_state", state, 0);
        cpu_req = 1'b0;
        cpu_last = 32'h0; dbg_last = 32'h0;
        @(negedge clk);
        check_reset_outputs("rst_mid");
        rst_n = 1'b1;
        @(negedge clk);
        cpu_access(1'b0, 32'h1000_0020, 32'h0, 4'h0);
        check("read_after_reset", cpu_rddata, 32'hCAFE_F00D);

        // tie from reset: CPU, DBG, CPU, DBG with idle cycles between
        rst_n = 1'b0;
        cpu_last = 32'h0; dbg_last = 32'h0;
        cpu_req = 1'b1; cpu_write = 1'b0; cpu_address = 32'h1000_0010;
        dbg_req = 1'b1; dbg_write = 1'b0; dbg_address = 32'h1000_FFFC;
        @(negedge clk);
        check_reset_outputs("tie_reset");
        for (int k = 0; k < 2; k++) begin
            predict_cpu(1'b0, 32'h1000_0010, 32'h0, 4'h0);
            predict_dbg(1'b0, 32'h1000_FFFC, 32'h0);
        end
        rst_n = 1'b1;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            check($sformatf("tie_pulse_%0d", k), {cpu_ready, dbg_ack}, tie_pat[k]);
        end
        cpu_req = 1'b0; dbg_req = 1'b0;
        @(negedge clk);

        // random mix on both ports (preload so every legal word is defined)
        for (int k = 0; k < 6; k++) dbg_access(1'b1, addr_tbl[k], $urandom);
        for (int k = 0; k < 40; k++) begin
            logic [31:0] a;
            a = addr_tbl[$urandom_range(0, 5)];
            if ($urandom_range(0, 1) == 1)
                cpu_access($urandom_range(0, 1) == 1, a, $urandom, 4'($urandom_range(0, 15)));
            else
                dbg_access($urandom_range(0, 1) == 1, a, $urandom);
        end

        repeat (3) @(negedge clk);
        check("cpu_queue_drained", exp_cpu_q.size(), 0);
        check("dbg_queue_drained", exp_dbg_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global time limit.
    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
